// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the shift sequencer: FSM states, core modes,
// direction encoding and default geometry.
package shift_seq_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNTW  = 3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CORE_HOLD = 2'd0,
        CORE_LOAD = 2'd1,
        CORE_SHL  = 2'd2,
        CORE_SHR  = 2'd3
    } core_mode_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Requester/controller bundle for shift_seq_ctrl. The master side is the pair of
// requesters; the slave side is the sequencer. DbgState exposes the FSM state.
interface shift_seq_ctrl_if
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNTW  = DEF_CNTW
);
    // Handshake: ReqN is held high until GntN is seen; GntN is a one-cycle pulse
    // at the edge where the request was accepted. Done/DoneId pulse one cycle
    // when the result on Po is final.
    logic             Req0;
    logic             Req1;
    logic [WIDTH-1:0] Pi0;
    logic [WIDTH-1:0] Pi1;
    logic [CNTW-1:0]  Cnt0;
    logic [CNTW-1:0]  Cnt1;
    logic             Dir0;
    logic             Dir1;
    logic             Gnt0;
    logic             Gnt1;
    logic             Busy;
    logic [WIDTH-1:0] Po;
    logic             Done;
    logic             DoneId;
    state_t           DbgState;

    modport master (
        output Req0, Req1, Pi0, Pi1, Cnt0, Cnt1, Dir0, Dir1,
        input  Gnt0, Gnt1, Busy, Po, Done, DoneId, DbgState
    );

    modport slave (
        input  Req0, Req1, Pi0, Pi1, Cnt0, Cnt1, Dir0, Dir1,
        output Gnt0, Gnt1, Busy, Po, Done, DoneId, DbgState
    );

endinterface

// File: rtl/shift_seq_core.sv
// WIDTH-bit shift register with hold/load/shift-left/shift-right and sync clear.
// SHIFT_SEQ_ROTATE_EN selects rotation; otherwise vacated bits are zero-filled.
module shift_seq_core
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  core_mode_t       mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;

`ifdef SHIFT_SEQ_ROTATE_EN
    assign shl = {q[WIDTH-2:0], q[WIDTH-1]};
    assign shr = {q[0], q[WIDTH-1:1]};
`else
    assign shl = {q[WIDTH-2:0], 1'b0};
    assign shr = {1'b0, q[WIDTH-1:1]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (mode)
                CORE_LOAD: q <= d;
                CORE_SHL:  q <= shl;
                CORE_SHR:  q <= shr;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Round-robin two-requester sequencer for the shift register core.
// Build option: SHIFT_SEQ_ROTATE_EN turns shifts into rotations.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNTW  = DEF_CNTW
) (
    input logic             Clk,
    input logic             Rst,
    shift_seq_ctrl_if.slave bus
);

    state_t           state;
    logic [CNTW-1:0]  cnt;
    logic             dir;
    logic             ptr;
    logic             gnt0;
    logic             gnt1;
    logic             done;
    logic             done_id;

    logic             any_req;
    logic             win1;
    logic [CNTW-1:0]  cnt_sel;
    logic [CNTW-1:0]  cnt_clamp;
    logic [WIDTH-1:0] pi_sel;
    core_mode_t       core_mode;
    logic [WIDTH-1:0] po;

    // Requester 1 wins when alone, or when both ask and the pointer favours it.
    assign any_req   = bus.Req0 | bus.Req1;
    assign win1      = bus.Req1 & (~bus.Req0 | ptr);
    assign cnt_sel   = win1 ? bus.Cnt1 : bus.Cnt0;
    assign pi_sel    = win1 ? bus.Pi1 : bus.Pi0;
    assign cnt_clamp = (cnt_sel > CNTW'(WIDTH)) ? CNTW'(WIDTH) : cnt_sel;

    always_comb begin
        core_mode = CORE_HOLD;
        if (state == IDLE && any_req) begin
            core_mode = CORE_LOAD;
        end else if (state == SHIFT) begin
            core_mode = (dir == DIR_RIGHT) ? CORE_SHR : CORE_SHL;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            cnt     <= '0;
            dir     <= DIR_LEFT;
            ptr     <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt0    <= ~win1;
                        gnt1    <= win1;
                        done_id <= win1;
                        ptr     <= ~win1;
                        dir     <= win1 ? bus.Dir1 : bus.Dir0;
                        cnt     <= cnt_clamp;
                        if (cnt_clamp == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    cnt <= cnt - 1'b1;
                    // The edge performing the final shift also raises Done.
                    if (cnt == CNTW'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    shift_seq_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk (Clk),
        .rst (Rst),
        .mode(core_mode),
        .d   (pi_sel),
        .q   (po)
    );

    assign bus.Gnt0     = gnt0;
    assign bus.Gnt1     = gnt1;
    assign bus.Done     = done;
    assign bus.DoneId   = done_id;
    assign bus.Busy     = (state != IDLE);
    assign bus.Po       = po;
    assign bus.DbgState = state;

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencer and two-requester arbiter for the team's parallel-in/parallel-out shift register. Each requester presents a parallel word, a shift count and a direction. The block arbitrates between them round-robin, loads the winner's word into the register and shifts it one bit per clock for the requested count. It then presents the result on `Po` with a one-cycle `Done` pulse tagged with the requester ID. It sits between the register datapath and its users, so the register never needs a per-user copy.

## Interface
- `WIDTH`, 4, data width of the shift register
- `CNTW`, 3, shift-count width; must satisfy 2^CNTW > WIDTH
- `Clk`  in  1  rising-edge clock
- `Rst`  in  1  synchronous, active-high reset
- `Req0`, `Req1`  in  1  request; held high until the matching `Gnt` is seen
- `Pi0`, `Pi1`  in  WIDTH  parallel load word for each requester
- `Cnt0`, `Cnt1`  in  CNTW  number of single-bit shifts
- `Dir0`, `Dir1`  in  1  shift direction: 0 = left (toward MSB), 1 = right
- `Gnt0`, `Gnt1`  out  1  registered one-cycle grant pulse
- `Busy`  out  1  high whenever the FSM is not in IDLE
- `Po`  out  WIDTH  register contents; holds the final value until the next load
- `Done`  out  1  one-cycle pulse marking a completed operation
- `DoneId`  out  1  requester ID for the current `Done`

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - If no `Req` is high, the FSM stays in IDLE.
  - If any `Req` is high, at that edge:
    - the arbiter picks the winner;
    - `Pi`, clamped count and `Dir` of the winner are captured;
    - `Gnt` of the winner is set, `DoneId` is set to the winner's ID, and the round-robin pointer moves to the other requester;
    - next state is SHIFT if count > 0, otherwise DONE.
- **SHIFT:**
  - Each cycle the register shifts one bit in `Dir` and the count decrements.
  - The edge that performs the last shift moves the FSM to DONE.
- **DONE:** `Done` is high for this one cycle, then the FSM returns to IDLE.
- **Arbitration:**
  - If only one `Req` is high, that requester wins.
  - If both are high, the requester named by the pointer wins.
  - After reset the pointer favours requester 0.
- **Requests outside IDLE:** ignored; no `Gnt` is issued and nothing is queued.
- **Req withdrawn:** a `Req` dropped before its grant has no effect.
- **Count clamp:** a count greater than WIDTH is clamped to WIDTH.
- **Zero-fill:** with the default build, vacated bits are filled with 0.
- **Reset (at any time, including mid-SHIFT):**
  - FSM goes to IDLE and `Po` clears to 0.
  - `Gnt0`, `Gnt1`, `Done` and `DoneId` clear to 0; `Busy` clears to 0.
  - Pointer returns to requester 0.
  - An aborted operation produces no `Done`.

## Timing
- Take cycle t as the IDLE cycle in which a `Req` is sampled.
- **Grant:** `Gnt` is high during cycle t+1 only.
- **Load:** `Po` equals the loaded word in cycle t+1.
- **Done latency:** `Done` is high in cycle t+1+N, where N is the clamped count.
  - For N = 0, `Done` and `Gnt` are high in the same cycle, t+1.
- **Back-to-back spacing:** the earliest next acceptance edge is the cycle after DONE, giving a throughput of one operation per N+2 cycles.
- **Busy:** high from t+1 through the DONE cycle inclusive.
- **Releasing Req:** a requester may drop `Req` at the edge ending cycle t+1.

## Configuration
- Macro: `SHIFT_SEQ_ROTATE_EN`.
- **Defined:** shifts are rotations; the bit shifted out re-enters at the opposite end. A clamped count of WIDTH therefore returns the original word.
- **Undefined:** zero-fill logical shifts, so a count of WIDTH yields all zeros.

## Structure
- **Package `shift_seq_pkg`:**
  - FSM state enum (IDLE/SHIFT/DONE);
  - direction constants `DIR_LEFT = 0`, `DIR_RIGHT = 1`;
  - default `WIDTH` and `CNTW`.
- **Sub-module `shift_seq_core`:**
  - WIDTH-bit register holding `Po`;
  - modes: hold / load / shift left / shift right;
  - synchronous clear;
  - rotate-versus-zero-fill selected by the macro.
- **Top level:** contains the FSM, counter, arbiter and pointer.

## Test plan
- **Single left shift:** `Req0`, `Pi0`=4'b0101, `Cnt0`=1, `Dir0`=0 → `Gnt0` at t+1, `Po`=4'b1010 with `Done`=1 and `DoneId`=0 at t+2.
- **Right shift by 2:** `Req1`, `Pi1`=4'b0110, `Cnt1`=2, `Dir1`=1 → `Po`=4'b0001 and `Done` at t+3, `DoneId`=1.
- **Simultaneous requests after reset:**
  - Stimulus: `Req0`/`Req1` both high, `Pi0`=4'b1110 (`Cnt0`=1, left), `Pi1`=4'b0011 (`Cnt1`=1, right).
  - Response: `Gnt0` first with `Po`=4'b1100; then `Gnt1` at the first IDLE cycle with `Po`=4'b0001; both `Req` dropped after grant.
- **Count clamp:** `Cnt0`=7, `Pi0`=4'b1011, left → `Done` at t+5 with `Po`=4'b0000; with `SHIFT_SEQ_ROTATE_EN` defined, `Po`=4'b1011.
- **Zero count:** `Cnt0`=0, `Pi0`=4'b1001 → `Gnt0` and `Done` both at t+1, `Po`=4'b1001.
- **Reset mid-SHIFT:**
  - Stimulus: `Rst` asserted for one cycle during SHIFT of a `Cnt`=3 operation.
  - Response: next cycle `Po`=0, `Busy`=0, and no `Done` ever appears.
  - Follow-up: a subsequent simultaneous request grants requester 0.
